hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard unit for the MIPS core, sitting beside the decode-stage controller. It tracks in-flight register writers across a configurable number of post-decode stages using Tnew countdown. It compares each writer against the decode instruction's Tuse to produce a stall and a forward-source select per operand. It also owns the multiply/divide busy counter, stalling MD-class instructions while the unit is occupied.

---
 rtl/hazard_scoreboard.sv | 190 +++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage hazard unit: Tnew/Tuse stall, forward select, MDU busy
//
// Tracks in-flight GPR writers across STAGES post-decode stages. Each entry
// holds {valid, dst, tnew} and shifts one stage per clock while its tnew
// counts down. The decode instruction's operands are compared against the
// youngest matching writer to produce a stall and a forward-source select.
// A multiply/divide busy counter stalls MD-class instructions while the
// MDU is occupied.
//
// Optional build macro: HAZARD_STATS_EN adds stall_cnt / md_stall_cnt.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   d_valid                       decode slot holds a real instruction
//   d_rs, d_rt, d_tuse_rs/rt      source indices and cycles until needed (all-ones = unused)
//   d_we, d_dst, d_tnew           destination write enable, index, cycles until ready at D
//   d_md, d_md_start, d_md_div    MDU use, multi-cycle launch, divide(1)/multiply(0)
//   flush                         exception/eret flush
//   stall                         freeze PC and D, bubble into E
//   fwd_sel_rs, fwd_sel_rt        0 = regfile, i = stage i
//   md_busy                       MDU counter nonzero
//   stall_cnt, md_stall_cnt       (HAZARD_STATS_EN only) saturating stall cycle counters

module hazard_scoreboard #(
  parameter int STAGES      = 3,
  parameter int REG_AW      = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic              d_we,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              flush,
  output logic              stall,
  output logic [2:0]        fwd_sel_rs,
  output logic [2:0]        fwd_sel_rt,
  output logic              md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt
`endif
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MDW    = $clog2(MD_MAX + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  logic [STAGES:1]   valid_q, valid_d;
  logic [REG_AW-1:0] dst_q  [1:STAGES];
  logic [REG_AW-1:0] dst_d  [1:STAGES];
  logic [TW-1:0]     tnew_q [1:STAGES];
  logic [TW-1:0]     tnew_d [1:STAGES];
  logic [MDW-1:0]    md_cnt_q, md_cnt_d;

  logic          rs_hit, rt_hit;
  logic [2:0]    rs_sel, rt_sel;
  logic [TW-1:0] rs_tnew, rt_tnew;
  logic          rs_stall, rt_stall, md_stall;

  // Youngest-match search: walk from oldest to youngest so the lowest
  // index that matches is the one left standing. $0 never matches.
  always_comb begin
    rs_hit  = 1'b0;
    rs_sel  = 3'd0;
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_sel  = 3'd0;
    rt_tnew = '0;
    for (int i = STAGES; i >= 1; i--) begin
      if (valid_q[i] && (dst_q[i] == d_rs) && (d_rs != '0)) begin
        rs_hit  = 1'b1;
        rs_sel  = 3'(i);
        rs_tnew = tnew_q[i];
      end
      if (valid_q[i] && (dst_q[i] == d_rt) && (d_rt != '0)) begin
        rt_hit  = 1'b1;
        rt_sel  = 3'(i);
        rt_tnew = tnew_q[i];
      end
    end
  end

  assign md_busy  = reset_n && (md_cnt_q != '0);
  assign rs_stall = rs_hit && (d_tuse_rs != TUSE_NONE) && (rs_tnew > d_tuse_rs);
  assign rt_stall = rt_hit && (d_tuse_rt != TUSE_NONE) && (rt_tnew > d_tuse_rt);
  assign md_stall = d_valid && d_md && md_busy;

  // Flush overrides every stall source so the flushed slot becomes a bubble.
  assign stall      = reset_n && !flush && (rs_stall || rt_stall || md_stall);
  assign fwd_sel_rs = reset_n ? rs_sel : 3'd0;
  assign fwd_sel_rt = reset_n ? rt_sel : 3'd0;

  always_comb begin
    valid_d = '0;
    for (int i = 1; i <= STAGES; i++) begin
      dst_d[i]  = '0;
      tnew_d[i] = '0;
    end

    // Age every entry one stage; tnew saturates at zero.
    for (int i = 2; i <= STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      dst_d[i]   = dst_q[i-1];
      tnew_d[i]  = (tnew_q[i-1] != '0) ? (tnew_q[i-1] - TW'(1)) : '0;
    end

    // Insert the decode instruction unless it is a bubble, stalled or flushed.
    if (!stall && !flush && d_valid) begin
      valid_d[1] = d_we && (d_dst != '0);
      dst_d[1]   = d_dst;
      tnew_d[1]  = (d_tnew != '0) ? (d_tnew - TW'(1)) : '0;
    end

    // The last tracked stage is already committed and survives a flush.
    if (flush) begin
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = 1'b0;
      end
    end

    // A flush does not cancel an MDU op that is already running.
    if (d_valid && d_md_start && !stall && !flush) begin
      md_cnt_d = d_md_div ? MDW'(DIV_CYCLES) : MDW'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= '0;
      md_cnt_q <= '0;
      for (int i = 1; i <= STAGES; i++) begin
        dst_q[i]  <= '0;
        tnew_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      md_cnt_q <= md_cnt_d;
      for (int i = 1; i <= STAGES; i++) begin
        dst_q[i]  <= dst_d[i];
        tnew_q[i] <= tnew_d[i];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    md_stall_cnt_d = md_stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (md_stall && (md_stall_cnt_q != 32'hFFFF_FFFF)) begin
      md_stall_cnt_d = md_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_we, d_md, d_md_start, d_md_div;
  logic       flush;
  logic       stall;
  logic [2:0] fwd_sel_rs, fwd_sel_rt;
  logic       md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_we       (d_we),
    .d_dst      (d_dst),
    .d_tnew     (d_tnew),
    .d_md       (d_md),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel_rs (fwd_sel_rs),
    .fwd_sel_rt (fwd_sel_rt),
    .md_busy    (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic dec(input logic v, input int rs, input int trs, input int rt, input int trt,
                     input logic we, input int dst, input int tn,
                     input logic md, input logic st, input logic dv);
    d_valid    = v;
    d_rs       = 5'(rs);
    d_tuse_rs  = 2'(trs);
    d_rt       = 5'(rt);
    d_tuse_rt  = 2'(trt);
    d_we       = we;
    d_dst      = 5'(dst);
    d_tnew     = 2'(tn);
    d_md       = md;
    d_md_start = st;
    d_md_div   = dv;
  endtask

  task automatic idle();
    dec(1'b0, 0, 3, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 4; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    flush   = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();

    // Outputs held low during reset even with a hazard-looking decode.
    dec(1'b1, 8, 0, 8, 0, 1'b1, 8, 3, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd_rs", 32'(fwd_sel_rs), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    tick();
    reset_n = 1'b1;
    drain();

    // lw $8 (tnew 3) then add $8,$8 (rs tuse 1): one stall, then forward from M.
    dec(1'b1, 29, 1, 0, 3, 1'b1, 8, 3, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lw_nostall", 32'(stall), 0);
    tick();
    dec(1'b1, 8, 1, 0, 3, 1'b1, 8, 2, 1'b0, 1'b0, 1'b0);
    #1;
    chk("add_stall", 32'(stall), 1);
    chk("add_fwd_e", 32'(fwd_sel_rs), 1);
    tick();
    #1;
    chk("add_release", 32'(stall), 0);
    chk("add_fwd_m", 32'(fwd_sel_rs), 2);
    tick();
    dec(1'b1, 8, 2, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("add_in_e1_fwd", 32'(fwd_sel_rs), 1);
    chk("add_in_e1_nostall", 32'(stall), 0);
    d_tuse_rs = 2'd0;
    #1;
    chk("add_in_e1_tnew1", 32'(stall), 1);
    tick();
    drain();

    // ori $9 (tnew 2) then sw reading rt=$9 (tuse 2): forward from E, no stall.
    dec(1'b1, 0, 3, 0, 3, 1'b1, 9, 2, 1'b0, 1'b0, 1'b0);
    tick();
    dec(1'b1, 29, 1, 9, 2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("sw_nostall", 32'(stall), 0);
    chk("sw_fwd_rt", 32'(fwd_sel_rt), 1);
    chk("sw_fwd_rs", 32'(fwd_sel_rs), 0);
    tick();
    drain();

    // ori $5 then lw $5: the younger lw wins the match.
    dec(1'b1, 0, 3, 0, 3, 1'b1, 5, 2, 1'b0, 1'b0, 1'b0);
    tick();
    dec(1'b1, 29, 1, 0, 3, 1'b1, 5, 3, 1'b0, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5, 0, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("young_stall", 32'(stall), 1);
    chk("young_fwd", 32'(fwd_sel_rs), 1);
    d_tuse_rs = 2'd3;
    #1;
    chk("unused_nostall", 32'(stall), 0);
    chk("unused_fwd", 32'(fwd_sel_rs), 1);
    d_tuse_rs = 2'd0;
    tick();
    #1;
    chk("young_m_stall", 32'(stall), 1);
    chk("young_m_fwd", 32'(fwd_sel_rs), 2);
    tick();
    #1;
    chk("young_w_stall", 32'(stall), 0);
    chk("young_w_fwd", 32'(fwd_sel_rs), 3);
    tick();
    drain();

    // div then mflo: ten busy/stall cycles.
    dec(1'b1, 0, 3, 0, 3, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("div_launch_nostall", 32'(stall), 0);
    tick();
    dec(1'b1, 0, 3, 0, 3, 1'b1, 2, 2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("div_busy", 32'(md_busy), 1);
      chk("div_stall", 32'(stall), 1);
      tick();
    end
    #1;
    chk("div_release", 32'(stall), 0);
    chk("div_idle", 32'(md_busy), 0);
    tick();

    // mult then mflo: five busy/stall cycles.
    dec(1'b1, 0, 3, 0, 3, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 0, 3, 0, 3, 1'b1, 2, 2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mult_stall", 32'(stall), 1);
      tick();
    end
    #1;
    chk("mult_release", 32'(stall), 0);
    chk("mult_idle", 32'(md_busy), 0);
    tick();
    drain();

    // Flush with entries 1..3 valid and a mult in flight.
    dec(1'b1, 0, 3, 0, 3, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int k = 11; k <= 13; k++) begin
      dec(1'b1, 0, 3, 0, 3, 1'b1, k, 3, 1'b0, 1'b0, 1'b0);
      #1;
      chk("fl_fill_nostall", 32'(stall), 0);
      tick();
    end
    dec(1'b1, 13, 0, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall_forced0", 32'(stall), 0);
    chk("fl_fwd_indep", 32'(fwd_sel_rs), 1);
    chk("fl_busy", 32'(md_busy), 1);
    tick();
    flush = 1'b0;
    dec(1'b1, 12, 0, 13, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fl_e3_kept", 32'(fwd_sel_rs), 3);
    chk("fl_e12_gone", 32'(fwd_sel_rt), 0);
    chk("fl_after_stall", 32'(stall), 0);
    chk("fl_md_counts", 32'(md_busy), 1);
    tick();
    idle();
    #1;
    chk("fl_md_done", 32'(md_busy), 0);
    drain();

    // Writer to $0 never creates a hazard.
    dec(1'b1, 0, 3, 0, 3, 1'b1, 0, 3, 1'b0, 1'b0, 1'b0);
    tick();
    dec(1'b1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("r0_stall", 32'(stall), 0);
    chk("r0_fwd_rs", 32'(fwd_sel_rs), 0);
    chk("r0_fwd_rt", 32'(fwd_sel_rt), 0);
    tick();
    drain();

    // Reset in the middle of a divide with a live writer.
    dec(1'b1, 0, 3, 0, 3, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    dec(1'b1, 0, 3, 0, 3, 1'b1, 7, 3, 1'b0, 1'b0, 1'b0);
    tick();
    dec(1'b1, 7, 0, 0, 3, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mid_pre_stall", 32'(stall), 1);
    chk("mid_pre_fwd", 32'(fwd_sel_rs), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_busy", 32'(md_busy), 0);
    chk("mid_rst_fwd", 32'(fwd_sel_rs), 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("mid_post_busy", 32'(md_busy), 0);
    chk("mid_post_fwd", 32'(fwd_sel_rs), 0);
    chk("mid_post_stall", 32'(stall), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
